// File: rtl/idli_pin_unit.sv
// idli_pin_unit: slice-serial general-purpose pin unit for the idli core.
// Executes PIN_OP_IN / PIN_OP_OUT / PIN_OP_OUTN / PIN_OP_OUTP over the
// four-cycle, 4-bit-slice datapath and feeds the PIPE_IO result leg.
//
// Optional feature: define IDLI_PIN_EDGE_EN to build sticky rising-edge
// capture. IN then returns {zext8(edge), zext8(sync)}. With the feature
// enabled NUM_PINS must be 1..8; otherwise 1..16.
//
// pin_op_t encoding: IN=0, OUT=1, OUTN=2, OUTP=3.

module idli_pin_unit #(
   parameter int                  NUM_PINS    = 4,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [NUM_PINS-1:0] RST_PINS    = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_ctr,
   input  logic                i_vld,
   input  logic [1:0]          i_op,
   input  logic [3:0]          i_data,
   input  logic                i_p,
   output logic [3:0]          o_data,
   input  logic [NUM_PINS-1:0] i_pins,
   output logic [NUM_PINS-1:0] o_pins
);

   typedef enum logic [1:0] {
      PIN_OP_IN   = 2'd0,
      PIN_OP_OUT  = 2'd1,
      PIN_OP_OUTN = 2'd2,
      PIN_OP_OUTP = 2'd3
   } pin_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                                r_state;
   state_t                                w_stateNext;
   pin_op_t                               r_op;
   logic [3:0]                            r_idx;
   logic                                  r_outBit;
   logic [15:0]                           r_snap;
   logic [SYNC_STAGES-1:0][NUM_PINS-1:0]  r_sync;
   logic [NUM_PINS-1:0]                   r_pins;
   logic [NUM_PINS-1:0]                   w_sync;
   logic [15:0]                           w_inValue;
   logic                                  w_accept;
   logic                                  w_commit;
   logic                                  w_pinVal;

`ifdef IDLI_PIN_EDGE_EN
   logic [NUM_PINS-1:0]                   r_edge;
   logic [NUM_PINS-1:0]                   r_syncDly;
   logic [NUM_PINS-1:0]                   w_edgeRise;
   logic [NUM_PINS-1:0]                   w_edgeClr;
`endif

   // The last synchroniser stage is the only view of the pins the core sees.
   assign w_sync = r_sync[SYNC_STAGES-1];

   // An op is taken only at slice 0 while idle; commit is the slice-3 cycle.
   assign w_accept = (r_state == ST_IDLE) && (i_ctr == 2'd0) && i_vld;
   assign w_commit = (r_state == ST_BUSY) && (i_ctr == 2'd3);

   assign o_pins = r_pins;

   // Shift the external pins through the synchroniser chain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         for (int s = SYNC_STAGES - 1; s > 0; s--) begin
            r_sync[s] <= r_sync[s-1];
         end
         r_sync[0] <= i_pins;
      end
   end

`ifdef IDLI_PIN_EDGE_EN
   // A 0->1 transition of a synchronised pin is a rising edge.
   assign w_edgeRise = w_sync & ~r_syncDly;

   // Only the flags an IN op actually returned are cleared at its commit.
   always_comb begin
      w_edgeClr = '0;
      if (w_commit && (r_op == PIN_OP_IN)) begin
         w_edgeClr = r_snap[8 +: NUM_PINS];
      end
   end

   // Sticky edge flags; a rise in the commit cycle beats the clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_edge    <= '0;
         r_syncDly <= '0;
      end else begin
         r_edge    <= (r_edge & ~w_edgeClr) | w_edgeRise;
         r_syncDly <= w_sync;
      end
   end
`endif

   // Assemble the 16-bit value an IN op returns from the live pin state.
   always_comb begin
      w_inValue = '0;
      for (int i = 0; i < NUM_PINS; i++) begin
         w_inValue[i] = w_sync[i];
      end
`ifdef IDLI_PIN_EDGE_EN
      for (int i = 0; i < NUM_PINS; i++) begin
         w_inValue[8+i] = r_edge[i];
      end
`endif
   end

   // State register: idle until an op is accepted, busy through slice 3.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic; i_vld outside slice 0 never starts an op.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_stateNext = ST_BUSY;
         ST_BUSY: if (i_ctr == 2'd3) w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Result slices: slice 0 is live from sync, slices 1..3 from the snapshot.
   always_comb begin
      o_data = 4'h0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (pin_op_t'(i_op) == PIN_OP_IN)) begin
               o_data = w_inValue[3:0];
            end
         end
         ST_BUSY: begin
            if (r_op == PIN_OP_IN) begin
               case (i_ctr)
                  2'd1:    o_data = r_snap[7:4];
                  2'd2:    o_data = r_snap[11:8];
                  2'd3:    o_data = r_snap[15:12];
                  default: o_data = 4'h0;
               endcase
            end
         end
         default: o_data = 4'h0;
      endcase
   end

   // Latch op, pin index, snapshot and the OUT operand bit as slices arrive.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op     <= PIN_OP_IN;
         r_idx    <= 4'h0;
         r_outBit <= 1'b0;
         r_snap   <= '0;
      end else begin
         if (w_accept) begin
            r_op   <= pin_op_t'(i_op);
            r_idx  <= i_data;
            r_snap <= w_inValue;
         end
         if ((r_state == ST_BUSY) && (i_ctr == 2'd1)) begin
            r_outBit <= i_data[0];
         end
      end
   end

   // Value an output op drives onto its pin at commit.
   always_comb begin
      w_pinVal = 1'b0;
      case (r_op)
         PIN_OP_OUT:  w_pinVal = r_outBit;
         PIN_OP_OUTP: w_pinVal = i_p;
         PIN_OP_OUTN: w_pinVal = ~i_p;
         default:     w_pinVal = 1'b0;
      endcase
   end

   // Output pins change only at commit; an index with no matching pin
   // falls through the loop and the write is dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pins <= RST_PINS;
      end else if (w_commit && (r_op != PIN_OP_IN)) begin
         for (int i = 0; i < NUM_PINS; i++) begin
            if (r_idx == 4'(i)) begin
               r_pins[i] <= w_pinVal;
            end
         end
      end
   end

endmodule
